// File: rtl/fp_add_issue.sv
// Valid/ready issue and collect shell around a fixed-latency FP adder.
// Outstanding-operation credits keep the result FIFO from ever overflowing.
module fp_add_issue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_op_a,
    input  logic [DATA_W-1:0]         in_op_b,
    output logic                      fpu_start,
    output logic [DATA_W-1:0]         fpu_op_a,
    output logic [DATA_W-1:0]         fpu_op_b,
    input  logic                      fpu_done,
    input  logic [DATA_W-1:0]         fpu_res,
    input  logic [2:0]                fpu_flags,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_res,
    output logic [2:0]                out_flags,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 3;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  occ_reg, occ_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  inflight;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic              in_ready_reg;
    logic              start_reg;
    logic [DATA_W-1:0] op_a_reg, op_b_reg;
    logic              proto_err_reg;
    logic              accept, pop, wr_en, done_bad, fifo_valid;
    logic [ENT_W-1:0]  head;
    logic [ENT_W-1:0]  mem [DEPTH];

    assign accept     = in_valid & in_ready_reg;
    assign fifo_valid = (cnt_reg != '0);
    assign pop        = fifo_valid & out_ready;
    assign inflight   = occ_reg - cnt_reg;

    // A done pulse with no room or nothing outstanding is dropped and flagged.
    assign done_bad = fpu_done & ((cnt_reg == FULL) | (inflight == '0));
    assign wr_en    = fpu_done & ~done_bad;

    always_comb begin
        occ_next = occ_reg;
        case ({accept, pop})
            2'b10:   occ_next = occ_reg + CNT_W'(1);
            2'b01:   occ_next = occ_reg - CNT_W'(1);
            default: occ_next = occ_reg;
        endcase
    end

    always_comb begin
        cnt_next = cnt_reg;
        case ({wr_en, pop})
            2'b10:   cnt_next = cnt_reg + CNT_W'(1);
            2'b01:   cnt_next = cnt_reg - CNT_W'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg       <= '0;
            cnt_reg       <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            in_ready_reg  <= 1'b0;
            start_reg     <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            occ_reg       <= occ_next;
            cnt_reg       <= cnt_next;
            // Ready is registered from the next credit count so it stays low in reset.
            in_ready_reg  <= (occ_next < FULL);
            start_reg     <= accept;
            proto_err_reg <= proto_err_reg | done_bad;
            if (accept) begin
                op_a_reg <= in_op_a;
                op_b_reg <= in_op_b;
            end
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {fpu_flags, fpu_res};
        end
    end

    // Head is gated by valid so stale storage never leaks out after reset.
    assign head      = mem[rd_ptr_reg];
    assign out_valid = fifo_valid;
    assign out_res   = fifo_valid ? head[DATA_W-1:0] : '0;
    assign out_flags = fifo_valid ? head[ENT_W-1:DATA_W] : 3'b000;

    assign in_ready  = in_ready_reg;
    assign fpu_start = start_reg;
    assign fpu_op_a  = op_a_reg;
    assign fpu_op_b  = op_b_reg;
    assign occupancy = occ_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_fp_add_issue.sv
// Scoreboard bench for fp_add_issue with a behavioural 5-cycle adder model.
module tb_fp_add_issue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_op_a = '0;
    logic [31:0]       in_op_b = '0;
    logic              fpu_start;
    logic [31:0]       fpu_op_a, fpu_op_b;
    logic              fpu_done;
    logic [31:0]       fpu_res;
    logic [2:0]        fpu_flags;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_res;
    logic [2:0]        out_flags;
    logic [3:0]        occupancy;
    logic              proto_err;

    logic              inj_done = 1'b0;
    logic [31:0]       inj_res  = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    logic [34:0] exp_q [$];

    always #5 clk = ~clk;

    fp_add_issue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_a(in_op_a), .in_op_b(in_op_b),
        .fpu_start(fpu_start), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
        .fpu_done(fpu_done), .fpu_res(fpu_res), .fpu_flags(fpu_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flags(out_flags),
        .occupancy(occupancy), .proto_err(proto_err)
    );

    // Hand-computed directed vectors: a + b = r with flags f.
    localparam logic [31:0] VA [8] = '{32'h3F800000, 32'h3FC00000, 32'hBF800000, 32'h41200000,
                                       32'h7F800000, 32'h42C80000, 32'hC0000000, 32'h40E00000};
    localparam logic [31:0] VB [8] = '{32'h40000000, 32'h40200000, 32'h3F000000, 32'hC1200000,
                                       32'h3F800000, 32'h3E800000, 32'hC0400000, 32'h3F800000};
    localparam logic [31:0] VR [8] = '{32'h40400000, 32'h40800000, 32'hBF000000, 32'h00000000,
                                       32'h7F800000, 32'h42C88000, 32'hC0A00000, 32'h41000000};
    localparam logic [2:0]  VF [8] = '{3'b000, 3'b000, 3'b000, 3'b000,
                                       3'b001, 3'b000, 3'b000, 3'b000};

    function automatic real sp_to_real(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'd0) return 0.0;
        d = {s[31], 11'(int'(s[30:23]) - 127 + 1023), s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b001, 32'h7F800000};
        return {3'b000, real_to_sp(sp_to_real(a) + sp_to_real(b))};
    endfunction

    // Adder stand-in: start sampled at edge S, done visible after edge S+4.
    logic [4:0]  pv;
    logic [34:0] pd [5];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < 5; i++) pd[i] <= '0;
        end else begin
            pv    <= {pv[3:0], fpu_start};
            pd[0] <= ref_add(fpu_op_a, fpu_op_b);
            for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
        end
    end
    assign fpu_done  = pv[4] | inj_done;
    assign fpu_res   = inj_done ? inj_res : pd[4][31:0];
    assign fpu_flags = inj_done ? 3'b000 : pd[4][34:32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic get_vec(input int idx, output logic [31:0] a, output logic [31:0] b,
                           output logic [31:0] r, output logic [2:0] f);
        if (idx < 8) begin
            a = VA[idx]; b = VB[idx]; r = VR[idx]; f = VF[idx];
        end else begin
            a = real_to_sp(real'(idx));
            b = real_to_sp(real'(2 * idx + 1));
            {f, r} = ref_add(a, b);
        end
    endtask

    task automatic offer(input int idx, output bit acc);
        logic [31:0] a, b, r;
        logic [2:0]  f;
        get_vec(idx, a, b, r, f);
        in_valid = 1'b1;
        in_op_a  = a;
        in_op_b  = b;
        acc = in_ready;
        if (acc) exp_q.push_back({f, r});
        $display("issue idx=%0d a=%h b=%h accepted=%0d", idx, a, b, acc);
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: a pop happens at the next edge whenever valid and ready are both high.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h, expected no result", out_res);
                end else begin
                    e = exp_q.pop_front();
                    $display("result res=%h flags=%b expected res=%h flags=%b",
                             out_res, out_flags, e[31:0], e[34:32]);
                    chk("out_res", out_res, e[31:0]);
                    chk("out_flags", out_flags, e[34:32]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (fpu_start) n_start++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int lat, accepts, s0;
        bit saw_valid;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_fpu_start", fpu_start, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Single operation and latency.
        out_ready = 1'b1;
        offer(0, acc);
        chk("single_accept", acc, 1);
        tick();
        in_valid = 1'b0;
        chk("single_start", fpu_start, 1);
        chk("single_op_a", fpu_op_a, 32'h3F800000);
        chk("single_op_b", fpu_op_b, 32'h40000000);
        tick();
        chk("single_start_pulse", fpu_start, 0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("single_latency", lat, 6);
        tick();
        chk("single_occ_after_pop", occupancy, 0);
        chk("single_out_valid_low", out_valid, 0);
        chk("single_op_a_hold", fpu_op_a, 32'h3F800000);

        // Fill with the consumer stalled.
        out_ready = 1'b0;
        s0 = n_start;
        accepts = 0;
        for (int i = 0; i < 12; i++) begin
            offer(i + 1, acc);
            if (acc) accepts++;
            tick();
        end
        in_valid = 1'b0;
        chk("fill_accepts", accepts, 8);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_occupancy", occupancy, 8);
        chk("fill_starts", n_start - s0, 8);
        out_ready = 1'b1;
        drain("fill_drain", 60);
        tick();
        chk("fill_in_ready_back", in_ready, 1);
        chk("fill_occ_empty", occupancy, 0);

        // Streaming with accept and pop together at occupancy 7.
        s0 = n_start;
        for (int i = 0; i < 100; i++) begin
            chk("stream_in_ready", in_ready, 1);
            if (i >= 7) begin
                chk("stream_no_bubble", out_valid, 1);
                chk("stream_occupancy", occupancy, 7);
            end
            offer(100 + i, acc);
            tick();
        end
        in_valid = 1'b0;
        drain("stream_drain", 40);
        chk("stream_starts", n_start - s0, 100);
        tick();
        chk("stream_occ_empty", occupancy, 0);

        // Reset with ops in flight and results stored.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            offer(20 + i, acc);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_occupancy", occupancy, 6);
        chk("mid_out_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_occupancy", occupancy, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_out_res", out_res, 0);
        chk("async_fpu_op_a", fpu_op_a, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_valid = saw_valid | out_valid;
        end
        chk("no_stale_results", saw_valid, 0);
        chk("after_rst_occupancy", occupancy, 0);
        offer(1, acc);
        chk("after_rst_accept", acc, 1);
        tick();
        in_valid = 1'b0;
        drain("after_rst_drain", 20);
        tick();
        chk("after_rst_occ", occupancy, 0);

        // Spurious done with nothing in flight.
        inj_done = 1'b1;
        inj_res  = 32'hDEADBEEF;
        tick();
        inj_done = 1'b0;
        chk("perr_set", proto_err, 1);
        chk("perr_no_write", out_valid, 0);
        chk("perr_occupancy", occupancy, 0);
        repeat (3) tick();
        chk("perr_sticky", proto_err, 1);
        offer(7, acc);
        tick();
        in_valid = 1'b0;
        drain("perr_drain", 20);
        chk("perr_still_set", proto_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("perr_cleared", proto_err, 0);

        repeat (5) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_add_issue.md
Name: fp_add_issue

Overview:
- Flow-control shell that sits directly upstream and downstream of the pipelined FP adder.
- Accepts operand pairs on a valid/ready stream and drives the adder's start/op_a/op_b inputs.
- Captures each result and flag set on the adder's done pulse into a result FIFO, and presents the results on a valid/ready output stream.
- Credit accounting guarantees a result can never arrive at a full FIFO. The adder has no backpressure; this block supplies it.

Parameters:
- DATA_W, 32, operand/result width; must match the adder instance.
- DEPTH, 8, result FIFO entries; power of two, >= 2. It is also the maximum number of outstanding operations.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset; shared with the adder instance
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- in_op_a  in  DATA_W  operand A
- in_op_b  in  DATA_W  operand B
- fpu_start  out  1  start pulse to adder
- fpu_op_a  out  DATA_W  operand A to adder
- fpu_op_b  out  DATA_W  operand B to adder
- fpu_done  in  1  adder done pulse
- fpu_res  in  DATA_W  adder result, valid when fpu_done=1
- fpu_flags  in  3  {overflow, underflow, exception} from adder, valid with fpu_done
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_res  out  DATA_W  head result
- out_flags  out  3  head flags
- occupancy  out  $clog2(DEPTH)+1  credits in use (issued minus popped)
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert): all outputs 0, occupancy 0, FIFO empty, proto_err 0. Operations in flight are discarded; the adder's pipeline clears on the same rst.
- Input handshake: accept = in_valid & in_ready.
  - in_ready = (occupancy < DEPTH). It is registered-state-only; no combinational path from out_ready or fpu_done.
- Issue timing: on accept, in_op_a/in_op_b are registered into fpu_op_a/fpu_op_b, and fpu_start=1 the next cycle. fpu_start is a 1-cycle pulse per accepted pair.
  - Back-to-back accepts give consecutive start pulses.
  - fpu_op_a/b hold their last value when there is no issue.
- Capture: on fpu_done=1, write {fpu_flags, fpu_res} to the FIFO tail the same edge. Results are stored in arrival order, which equals issue order because the adder has fixed latency.
- Output: out_valid = FIFO non-empty. out_res/out_flags show the head combinationally from storage (first-word fall-through). Pop = out_valid & out_ready.
- Occupancy counter: +1 on accept, -1 on pop. Simultaneous accept and pop leaves it unchanged.
  - Because occupancy counts in-flight plus stored entries, a FIFO write can never find the FIFO full.
- Pointers: $clog2(DEPTH)-bit read/write pointers wrap modulo DEPTH. The FIFO count is tracked separately, with a range of 0..DEPTH.
- Simultaneous FIFO write and pop:
  - When the FIFO is empty, the write lands and out_valid rises the next cycle.
  - A pop of an empty FIFO is impossible (out_valid=0).
- proto_err is set and held until rst by either condition below. In both cases the offending event is ignored: no write, and no counter underflow.
  - fpu_done=1 when FIFO count == DEPTH.
  - fpu_done=1 when in-flight count (occupancy - FIFO count) == 0.
- End-to-end latency with the 5-cycle adder: in_valid accepted at edge N -> fpu_start high in cycle N+1 -> fpu_done at N+6 -> out_valid high from N+7.

Test Plan:
- Single op: pair 0x3F800000 + 0x40000000 accepted with out_ready=1.
  - fpu_start pulses once, one cycle later.
  - out_valid rises 7 cycles after accept with out_res=0x40400000, out_flags=0.
  - occupancy returns to 0 after the pop.
- Fill: out_ready=0, in_valid=1 for 12 cycles with distinct pairs.
  - Exactly 8 accepted; in_ready=0 once occupancy=8.
  - Raise out_ready: 8 results emerge in order, then in_ready re-asserts.
- Streaming: in_valid=1 and out_ready=1 continuously for 100 pairs.
  - One result per cycle after the fill latency, no bubbles, occupancy steady at 7.
  - Results match a reference model.
- Simultaneous accept+pop at occupancy=DEPTH-1 -> occupancy stays 7; pointer wrap across 3 full FIFO cycles gives correct ordering.
- Reset mid-stream: assert rst with 4 ops in flight and 2 stored.
  - All outputs 0 immediately (async).
  - After release: no stale results, occupancy 0, first new op returns the correct result.
- Protocol error: inject fpu_done with nothing in flight.
  - proto_err=1 and sticky; FIFO count unchanged; cleared only by rst.
